// File: rtl/uart_loader_pkg.sv
// Shared constants and types for the UART program loader.
//   ASCII_* : byte codes understood by the decoder
//   OS_RATE : receiver oversampling factor (sample ticks per bit)
//   rx_state_t : receiver FSM states
package uart_loader_pkg;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_1  = 8'h31;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  localparam int unsigned OS_RATE = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_os16.sv
// 16x-oversampled UART byte receiver: 2-flop synchroniser, baud tick
// generator and receive FSM. Frame is 8N1, or 8E1 when UART_PARITY_EN is
// defined.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   rx          : asynchronous serial line, idle high
//   rx_byte     : last good byte (valid with rx_valid)
//   rx_valid    : one-cycle pulse, rx_byte is a well-framed byte
//   frame_err   : one-cycle pulse, byte dropped (bad stop or parity bit)
module uart_rx_os16
  import uart_loader_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 327
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam int unsigned CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned TW = $clog2(OS_RATE);
  localparam logic [TW-1:0] MID  = TW'(OS_RATE / 2 - 1);
  localparam logic [TW-1:0] LAST = TW'(OS_RATE - 1);

  logic            rx_meta;
  logic            rx_sync;
  logic [CW-1:0]   baud_ctr;
  logic            tick;
  rx_state_t       state;
  logic [TW-1:0]   tick_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
`ifdef UART_PARITY_EN
  logic            par_bad;
`endif

  assign tick = (baud_ctr == CW'(BAUD_DIV - 1));

  // Synchroniser, baud counter and receive FSM; the FSM moves only on ticks.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      baud_ctr  <= '0;
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      rx_byte   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_PARITY_EN
      par_bad   <= 1'b0;
`endif
    end else begin
      rx_meta   <= rx;
      rx_sync   <= rx_meta;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      baud_ctr  <= tick ? '0 : baud_ctr + CW'(1);
      if (tick) begin
        case (state)
          IDLE: begin
            if (!rx_sync) begin
              state    <= START;
              tick_cnt <= '0;
            end
          end
          // Re-check the line mid start bit to reject glitches.
          START: begin
            if (tick_cnt == MID) begin
              tick_cnt <= '0;
              bit_idx  <= '0;
              state    <= rx_sync ? IDLE : DATA;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          DATA: begin
            if (tick_cnt == LAST) begin
              tick_cnt <= '0;
              shift    <= {rx_sync, shift[7:1]};
              bit_idx  <= bit_idx + 3'd1;
              if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
`ifdef UART_PARITY_EN
          PARITY: begin
            if (tick_cnt == LAST) begin
              tick_cnt <= '0;
              par_bad  <= (rx_sync != (^shift));
              state    <= STOP;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
`endif
          STOP: begin
            if (tick_cnt == LAST) begin
              tick_cnt <= '0;
              state    <= IDLE;
`ifdef UART_PARITY_EN
              if (rx_sync && !par_bad) begin
`else
              if (rx_sync) begin
`endif
                rx_byte  <= shift;
                rx_valid <= 1'b1;
              end else begin
                frame_err <= 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/uart_instr_loader.sv
// UART program loader: ASCII '0'/'1' stream -> INSTR_W-bit words ->
// DEPTH-entry instruction memory. LF ends a program, pulses start and
// publishes the word count. CR is ignored.
// Optional feature: define UART_PARITY_EN for 8E1 framing.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   rx         : asynchronous UART line, idle high
//   rd_addr    : instruction read address
//   rd_data    : mem[rd_addr], registered, 1-cycle latency, read-first
//   start      : one-cycle pulse when a program load completes
//   count      : words in last completed program (0..DEPTH)
//   err        : sticky error flag, cleared only by reset
module uart_instr_loader
  import uart_loader_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 327,
  parameter int unsigned INSTR_W  = 13,
  parameter int unsigned DEPTH    = 256,
  localparam int unsigned ADDR_W  = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rx,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [INSTR_W-1:0]  rd_data,
  output logic                start,
  output logic [ADDR_W:0]     count,
  output logic                err
);

  localparam int unsigned BW = $clog2(INSTR_W + 1);

  logic [7:0]         rx_byte;
  logic               rx_valid;
  logic               frame_err;
  logic [INSTR_W-1:0] mem [DEPTH];
  logic [INSTR_W-1:0] shift_reg;
  logic [INSTR_W-1:0] wr_word;
  logic [BW-1:0]      bitcnt;
  logic [ADDR_W:0]    wr_ptr;
  logic               wr_pend;
  logic               mem_we;

  uart_rx_os16 #(
    .BAUD_DIV (BAUD_DIV)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .frame_err (frame_err)
  );

  // A completed word is committed only while the memory still has room.
  assign mem_we = wr_pend && (wr_ptr < (ADDR_W + 1)'(DEPTH));

  // Byte decoder, word assembler and write pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg <= '0;
      wr_word   <= '0;
      bitcnt    <= '0;
      wr_ptr    <= '0;
      wr_pend   <= 1'b0;
      start     <= 1'b0;
      count     <= '0;
      err       <= 1'b0;
    end else begin
      start   <= 1'b0;
      wr_pend <= 1'b0;
      if (frame_err) err <= 1'b1;
      if (wr_pend) begin
        if (mem_we) wr_ptr <= wr_ptr + (ADDR_W + 1)'(1);
        else        err    <= 1'b1;
      end
      if (rx_valid) begin
        case (rx_byte)
          ASCII_0, ASCII_1: begin
            shift_reg <= INSTR_W'({shift_reg, rx_byte == ASCII_1});
            if (bitcnt == BW'(INSTR_W - 1)) begin
              wr_word <= INSTR_W'({shift_reg, rx_byte == ASCII_1});
              wr_pend <= 1'b1;
              bitcnt  <= '0;
            end else begin
              bitcnt <= bitcnt + BW'(1);
            end
          end
          ASCII_CR: ;
          // End of program: any partial word is discarded and flagged.
          ASCII_LF: begin
            start  <= 1'b1;
            count  <= wr_ptr;
            wr_ptr <= '0;
            bitcnt <= '0;
            if (bitcnt != '0) err <= 1'b1;
          end
          default: err <= 1'b1;
        endcase
      end
    end
  end

  // Instruction memory write port (contents survive reset).
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr[ADDR_W-1:0]] <= wr_word;
  end

  // Registered read port; same-cycle write returns old data.
  always_ff @(posedge clk) begin
    if (reset) rd_data <= '0;
    else       rd_data <= mem[rd_addr];
  end

endmodule

// File: tb/tb_uart_instr_loader.sv
module tb_uart_instr_loader;

  localparam int unsigned BAUD_DIV = 4;
  localparam int unsigned INSTR_W  = 4;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned ADDR_W   = 2;
  localparam int BIT_CYC = 16 * BAUD_DIV;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               rx = 1'b1;
  logic [ADDR_W-1:0]  rd_addr = '0;
  logic [INSTR_W-1:0] rd_data;
  logic               start;
  logic [ADDR_W:0]    count;
  logic               err;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int width_bad = 0;
  logic start_prev = 1'b0;
`ifdef UART_PARITY_EN
  bit flip_parity = 1'b0;
`endif

  uart_instr_loader #(
    .BAUD_DIV (BAUD_DIV),
    .INSTR_W  (INSTR_W),
    .DEPTH    (DEPTH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .rx      (rx),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .start   (start),
    .count   (count),
    .err     (err)
  );

  always #5 clk = ~clk;

  // Count start pulses and flag any pulse longer than one cycle.
  always @(negedge clk) begin
    if (!reset && start) start_cnt++;
    if (!reset && start && start_prev) width_bad++;
    start_prev <= start;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    rx    = 1'b1;
    wait_cyc(4);
    reset = 1'b0;
    wait_cyc(4);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_stop);
    rx = 1'b0;
    wait_cyc(BIT_CYC);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cyc(BIT_CYC);
    end
`ifdef UART_PARITY_EN
    rx = (^b) ^ flip_parity;
    wait_cyc(BIT_CYC);
`endif
    if (bad_stop) begin
      rx = 1'b0;
      wait_cyc(BIT_CYC * 3 / 4);
      rx = 1'b1;
      wait_cyc(BIT_CYC / 4 + BIT_CYC);
    end else begin
      rx = 1'b1;
      wait_cyc(2 * BIT_CYC);
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_frame(s[i], 1'b0);
  endtask

  task automatic read_mem(input logic [ADDR_W-1:0] a, output logic [INSTR_W-1:0] d);
    @(negedge clk);
    rd_addr = a;
    @(negedge clk);
    d = rd_data;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wait_cyc(5);
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL reset_start got %b exp 0", start); end
    checks++; if (count !== '0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data got %h exp 0", rd_data); end
    reset = 1'b0;
    wait_cyc(4);
  endtask

  task automatic test_single();
    int s0;
    logic [INSTR_W-1:0] d;
    s0 = start_cnt;
    send_str("1010\n");
    checks++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL single_start got %0d exp 1", start_cnt - s0); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count got %0d exp 1", count); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL single_err got %b exp 0", err); end
    read_mem(2'd0, d);
    checks++; if (d !== 4'hA) begin errors++; $display("FAIL single_mem0 got %h exp a", d); end
  endtask

  task automatic test_crlf();
    int s0;
    logic [INSTR_W-1:0] d;
    do_reset();
    s0 = start_cnt;
    send_str("0001\r\n");
    checks++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL crlf_start1 got %0d exp 1", start_cnt - s0); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL crlf_count1 got %0d exp 1", count); end
    read_mem(2'd0, d);
    checks++; if (d !== 4'h1) begin errors++; $display("FAIL crlf_mem0_a got %h exp 1", d); end
    send_str("1111\n");
    checks++; if (start_cnt - s0 !== 2) begin errors++; $display("FAIL crlf_start2 got %0d exp 2", start_cnt - s0); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL crlf_count2 got %0d exp 1", count); end
    read_mem(2'd0, d);
    checks++; if (d !== 4'hF) begin errors++; $display("FAIL crlf_mem0_b got %h exp f", d); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL crlf_err got %b exp 0", err); end
  endtask

  task automatic test_full();
    int s0;
    logic [INSTR_W-1:0] d;
    logic [INSTR_W-1:0] exp_w;
    do_reset();
    s0 = start_cnt;
    send_str("0001001000110100");
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL full_err_at4 got %b exp 0", err); end
    send_str("0101");
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL full_err_at5 got %b exp 1", err); end
    send_str("\n");
    checks++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL full_start got %0d exp 1", start_cnt - s0); end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count got %0d exp 4", count); end
    for (int i = 0; i < 4; i++) begin
      exp_w = 4'(i + 1);
      read_mem(2'(i), d);
      checks++; if (d !== exp_w) begin errors++; $display("FAIL full_mem%0d got %h exp %h", i, d, exp_w); end
    end
  endtask

  task automatic test_partial_and_bad_char();
    int s0;
    do_reset();
    s0 = start_cnt;
    send_str("10\n");
    checks++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL partial_start got %0d exp 1", start_cnt - s0); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL partial_count got %0d exp 0", count); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL partial_err got %b exp 1", err); end
    do_reset();
    s0 = start_cnt;
    send_str("x");
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL badchar_err got %b exp 1", err); end
    checks++; if (start_cnt - s0 !== 0) begin errors++; $display("FAIL badchar_start got %0d exp 0", start_cnt - s0); end
  endtask

  task automatic test_frame_err();
    logic [INSTR_W-1:0] d;
    do_reset();
    send_frame(8'h31, 1'b1);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL frame_err got %b exp 1", err); end
    // A dropped '1' leaves the next word aligned: "0110" -> 6, not 0xB.
    send_str("0110\n");
    read_mem(2'd0, d);
    checks++; if (d !== 4'h6) begin errors++; $display("FAIL frame_drop_mem0 got %h exp 6", d); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL frame_count got %0d exp 1", count); end
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity();
    logic [INSTR_W-1:0] d;
    do_reset();
    flip_parity = 1'b1;
    send_frame(8'h31, 1'b0);
    flip_parity = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL parity_err got %b exp 1", err); end
    send_str("1001\n");
    read_mem(2'd0, d);
    checks++; if (d !== 4'h9) begin errors++; $display("FAIL parity_drop_mem0 got %h exp 9", d); end
  endtask
`endif

  task automatic test_reset_mid_frame();
    int s0;
    logic [INSTR_W-1:0] d;
    do_reset();
    // Start bit plus first three data bits of '1' (0x31, LSB first 1,0,0).
    rx = 1'b0; wait_cyc(BIT_CYC);
    rx = 1'b1; wait_cyc(BIT_CYC);
    rx = 1'b0; wait_cyc(2 * BIT_CYC);
    reset = 1'b1;
    rx    = 1'b1;
    wait_cyc(4);
    reset = 1'b0;
    wait_cyc(3 * BIT_CYC);
    s0 = start_cnt;
    send_str("0110\n");
    read_mem(2'd0, d);
    checks++; if (d !== 4'h6) begin errors++; $display("FAIL midrst_mem0 got %h exp 6", d); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL midrst_count got %0d exp 1", count); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL midrst_err got %b exp 0", err); end
    checks++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL midrst_start got %0d exp 1", start_cnt - s0); end
  endtask

  task automatic test_start_width();
    checks++; if (width_bad !== 0) begin errors++; $display("FAIL start_width long_pulses %0d exp 0", width_bad); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_crlf();
    test_full();
    test_partial_and_bad_char();
    test_frame_err();
`ifdef UART_PARITY_EN
    test_parity();
`endif
    test_reset_mid_frame();
    test_start_width();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
